tile_loop_ctrl: RTL and testbench
=================================

# tile_loop_ctrl

Two-level loop sequencer that walks a ROWS x COLS tile index space and hands one (row, col) index at a time to a datapath over a valid/ready handshake. It sits between the accelerator's top-level control and the per-tile compute/accumulate datapath. It replaces ad-hoc counter chaining with a single start/done, abortable controller. Internally it is built from two wrapping index counters.

## Interface
- ROWS, 4, outer loop trip count (>= 1)
- COLS, 8, inner loop trip count (>= 1)
- ROW_W, derived localparam, max(1, $clog2(ROWS))
- COL_W, derived localparam, max(1, $clog2(COLS))

Ports:
- clk  input  1  clock, all state updates on posedge
- rstn  input  1  reset, synchronous, active-low
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  terminate sweep; honoured in RUN
- idx_valid  output  1  row/col present a valid index
- idx_ready  input  1  datapath accepts index; fire = idx_valid & idx_ready
- row  output  ROW_W  current outer index
- col  output  COL_W  current inner index
- row_last  output  1  col == COLS-1 (qualified by idx_valid)
- last  output  1  row == ROWS-1 and col == COLS-1 (qualified by idx_valid)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after final index accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE: idx_valid=0, row=col=0. start=1 -> RUN; counters cleared.
- RUN: idx_valid=1. On fire: col+1; if col==COLS-1, col wraps to 0 and row+1. On fire with last=1 -> DONE, counters cleared.
- DONE: idx_valid=0, done=1 for exactly this cycle -> IDLE unconditionally.
- Abort in RUN -> IDLE next cycle, counters cleared, no done pulse. Abort outranks a same-cycle fire (that index counts as not consumed by control; datapath discards it).
- start in RUN or DONE ignored; abort in IDLE or DONE ignored.
- While idx_valid=1 and idx_ready=0, row/col/row_last/last hold stable; idx_valid never drops without fire or abort.
- Reset (rstn=0 at an edge): state IDLE, row=col=0, idx_valid=busy=done=0; applies mid-sweep identically.
- ROWS=1 and/or COLS=1: counters stay at 0; row_last/last asserted on every valid index accordingly.

## Timing
- start sampled at edge N -> idx_valid=1 with (0,0) from cycle N+1.
- One index per cycle with idx_ready held high; full sweep: ROWS*COLS RUN cycles + 1 DONE cycle.
- done high in the cycle after the final fire; busy high from N+1 through the DONE cycle inclusive.
- Earliest restart: start sampled in the cycle after done (IDLE).
- All outputs registered or decoded from registered state/counters only; no combinational path from idx_ready/start/abort to any output.

## Structure
- Shared package (tile_ctrl_pkg): state enum (IDLE, RUN, DONE) and the max(1,$clog2()) width helper function.
- Sub-module tile_idx_counter (parameter MAX_COUNT): inputs clk, rstn, clr, inc; outputs out, at_max (out==MAX_COUNT). inc at max wraps to 0; clr takes priority over inc. Two instances: col (MAX_COUNT=COLS-1, inc=fire), row (MAX_COUNT=ROWS-1, inc=fire & col at_max).
- FSM and handshake logic in tile_loop_ctrl top.

## Test plan
- Reset: hold rstn=0 3 cycles with start=1 -> all outputs 0, state IDLE; release -> start accepted next edge.
- ROWS=2, COLS=3, idx_ready=1: start -> indices (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on 6 consecutive cycles; row_last on col=2; last only on (1,2); done 1 cycle after; busy 7 cycles.
- Backpressure: idx_ready=0 for 5 cycles at (0,2) -> idx_valid=1, row=0, col=2, row_last=1 stable; sweep completes with exactly 6 fires.
- Abort at (1,0) with idx_ready=1 -> next cycle idx_valid=0, busy=0, no done; new start begins at (0,0).
- start pulsed mid-RUN ignored (sequence unchanged); rstn=0 at (0,1) -> next cycle IDLE, row=col=0, no done.
- ROWS=1, COLS=1 instance: start -> single index (0,0) with row_last=last=1, done next cycle.

Source files
------------

// File: rtl/tile_ctrl_pkg.sv
// Shared types and helpers for the tile loop sequencer.
// Holds the controller state encoding and an index-width function that never returns zero.
package tile_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A trip count of 1 still needs a 1-bit index port, so the width never drops to 0.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_idx_counter.sv
// Wrapping index counter: counts 0..MAX_COUNT, then wraps to 0 on the next increment.
// Updates one cycle after inc. A clear takes priority over a same-cycle increment.
module tile_idx_counter
    import tile_ctrl_pkg::*;
#(
    parameter int  MAX_COUNT = 7,
    localparam int W         = clog2_min1(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] out,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out    = cnt_q;
    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/tile_loop_ctrl.sv
// Two-level ROWS x COLS tile index sequencer with start/done/abort control.
// Presents (0,0) the cycle after start and one index per fire. Under idx_ready=0 it holds the index stable.
module tile_loop_ctrl
    import tile_ctrl_pkg::*;
#(
    parameter int  ROWS  = 4,
    parameter int  COLS  = 8,
    localparam int ROW_W = clog2_min1(ROWS),
    localparam int COL_W = clog2_min1(COLS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_last,
    output logic             last,
    output logic             busy,
    output logic             done
);

    state_e state_q;
    logic   valid_q;
    logic   busy_q;
    logic   done_q;

    logic   fire;
    logic   col_at_max;
    logic   row_at_max;
    logic   is_last;
    logic   cnt_clr;

    assign fire    = valid_q & idx_ready;
    assign is_last = row_at_max & col_at_max;
    // Counters sit at zero outside RUN. An abort discards a same-cycle fire, and the final fire rewinds for the next sweep.
    assign cnt_clr = ~valid_q | abort | (fire & is_last);

    tile_idx_counter #(
        .MAX_COUNT (COLS - 1)
    ) u_col_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (cnt_clr),
        .inc    (fire),
        .out    (col),
        .at_max (col_at_max)
    );

    tile_idx_counter #(
        .MAX_COUNT (ROWS - 1)
    ) u_row_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (cnt_clr),
        .inc    (fire & col_at_max),
        .out    (row),
        .at_max (row_at_max)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (fire && is_last) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign idx_valid = valid_q;
    assign row_last  = valid_q & col_at_max;
    assign last      = valid_q & is_last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tile_loop_ctrl.sv
// Bench for tile_loop_ctrl: a 2x3 instance driven through sweeps, stalls, aborts and resets, plus a 1x1 instance.
// Expected indices go into a queue when a sweep starts and are matched against every presented index.
module tb_tile_loop_ctrl;

    typedef struct packed {
        logic [0:0] row;
        logic [1:0] col;
        logic       rl;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, abort, idx_ready;
    logic       idx_valid, row_last, last, busy, done;
    logic [0:0] row;
    logic [1:0] col;

    logic       start1, abort1, idx_ready1;
    logic       idx_valid1, row_last1, last1, busy1, done1;
    logic [0:0] row1;
    logic [0:0] col1;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   fires, busy_cyc, done_cnt, done_gap;

    always #5 clk = ~clk;

    tile_loop_ctrl #(.ROWS(2), .COLS(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .row       (row),
        .col       (col),
        .row_last  (row_last),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    tile_loop_ctrl #(.ROWS(1), .COLS(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start1),
        .abort     (abort1),
        .idx_valid (idx_valid1),
        .idx_ready (idx_ready1),
        .row       (row1),
        .col       (col1),
        .row_last  (row_last1),
        .last      (last1),
        .busy      (busy1),
        .done      (done1)
    );

    // Runs one 2x3 sweep. Negative *_fire arguments disable that event; otherwise it triggers when that many fires have occurred.
    task automatic sweep(input int stall_n, input int abort_fire, input int start_fire, input int rst_fire);
        int  last_fire_cyc;
        int  stall_left;
        bit  ended;
        fires = 0; busy_cyc = 0; done_cnt = 0; done_gap = -1;
        last_fire_cyc = -100; stall_left = stall_n; ended = 0;
        sb.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                sb.push_back('{row: 1'(r), col: 2'(c), rl: (c == 2), last: (r == 1 && c == 2)});
        @(negedge clk);
        start = 1'b1; idx_ready = 1'b1; abort = 1'b0;
        for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rstn = 1'b1; idx_ready = 1'b1;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_gap = cyc - last_fire_cyc;
            end
            if (idx_valid) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL extra_index: got (%0d,%0d) but no index expected", row, col);
                end else if ({row, col, row_last, last} !== sb[0]) begin
                    $display("FAIL index: got row=%0d col=%0d rl=%0b last=%0b, want row=%0d col=%0d rl=%0b last=%0b",
                             row, col, row_last, last, sb[0].row, sb[0].col, sb[0].rl, sb[0].last);
                end else begin
                    n_pass++;
                end
                if (fires == abort_fire) begin
                    abort = 1'b1;
                    sb.delete();
                end else if (fires == rst_fire) begin
                    rstn = 1'b0;
                    sb.delete();
                end else begin
                    if (fires == start_fire) start = 1'b1;
                    if (stall_left > 0 && sb.size() > 0 && sb[0].row == 1'b0 && sb[0].col == 2'd2) begin
                        idx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        fires++;
                        last_fire_cyc = cyc;
                    end
                end
            end else if (!busy) begin
                ended = 1;
            end
        end
        n_total++;
        if (!ended) $display("FAIL sweep_timeout: busy=%0b idx_valid=%0b, want return to idle", busy, idx_valid);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL leftover: %0d indices never presented, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b1; abort = 1'b0; idx_ready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; idx_ready1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({idx_valid, busy, done, row_last, last, row, col} !== 8'd0)
                $display("FAIL reset_outputs: got %b, want 00000000", {idx_valid, busy, done, row_last, last, row, col});
            else n_pass++;
            n_total++;
            if ({idx_valid1, busy1, done1, row1, col1} !== 5'd0)
                $display("FAIL reset_outputs_1x1: got %b, want 00000", {idx_valid1, busy1, done1, row1, col1});
            else n_pass++;
        end
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if ({idx_valid, busy, row, col} !== 5'b11000)
            $display("FAIL start_after_reset: got valid/busy/row/col=%b, want 11000", {idx_valid, busy, row, col});
        else n_pass++;
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if ({idx_valid, busy, done} !== 3'b000)
            $display("FAIL abort_to_idle: got valid/busy/done=%b, want 000", {idx_valid, busy, done});
        else n_pass++;
    endtask

    task automatic test_basic_sweep;
        sweep(0, -1, -1, -1);
        n_total++;
        if (fires !== 6) $display("FAIL basic_fires: got %0d, want 6", fires); else n_pass++;
        n_total++;
        if (busy_cyc !== 7) $display("FAIL basic_busy: got %0d, want 7", busy_cyc); else n_pass++;
        n_total++;
        if (done_cnt !== 1 || done_gap !== 1)
            $display("FAIL basic_done: got count=%0d gap=%0d, want count=1 gap=1", done_cnt, done_gap);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        sweep(5, -1, -1, -1);
        n_total++;
        if (fires !== 6) $display("FAIL bp_fires: got %0d, want 6", fires); else n_pass++;
        n_total++;
        if (busy_cyc !== 12) $display("FAIL bp_busy: got %0d, want 12", busy_cyc); else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL bp_done: got %0d, want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_abort;
        sweep(0, 3, -1, -1);
        n_total++;
        if (fires !== 3 || done_cnt !== 0)
            $display("FAIL abort_result: got fires=%0d done=%0d, want fires=3 done=0", fires, done_cnt);
        else n_pass++;
        n_total++;
        if (busy_cyc !== 4) $display("FAIL abort_busy: got %0d, want 4", busy_cyc); else n_pass++;
        n_total++;
        if ({row, col} !== 3'd0) $display("FAIL abort_counters: got row/col=%b, want 000", {row, col}); else n_pass++;
    endtask

    task automatic test_restart_after_abort;
        sweep(0, -1, -1, -1);
        n_total++;
        if (fires !== 6 || done_cnt !== 1)
            $display("FAIL restart: got fires=%0d done=%0d, want fires=6 done=1", fires, done_cnt);
        else n_pass++;
    endtask

    task automatic test_start_mid_run;
        sweep(0, -1, 2, -1);
        n_total++;
        if (fires !== 6 || busy_cyc !== 7 || done_cnt !== 1)
            $display("FAIL start_ignored: got fires=%0d busy=%0d done=%0d, want 6/7/1", fires, busy_cyc, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        sweep(0, -1, -1, 1);
        n_total++;
        if (fires !== 1 || done_cnt !== 0)
            $display("FAIL reset_mid: got fires=%0d done=%0d, want fires=1 done=0", fires, done_cnt);
        else n_pass++;
        n_total++;
        if ({row, col, idx_valid, busy} !== 5'd0)
            $display("FAIL reset_mid_state: got row/col/valid/busy=%b, want 00000", {row, col, idx_valid, busy});
        else n_pass++;
    endtask

    task automatic test_single_tile;
        exp_t e;
        sb.delete();
        sb.push_back('{row: 1'b0, col: 2'd0, rl: 1'b1, last: 1'b1});
        @(negedge clk);
        start1 = 1'b1; idx_ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_total++;
        if (!idx_valid1 || !busy1 || sb.size() == 0) begin
            $display("FAIL single_valid: got valid=%0b busy=%0b, want 1/1", idx_valid1, busy1);
        end else begin
            e = sb.pop_front();
            if ({1'b0, col1} !== {e.col[1:0]} || row1 !== e.row || row_last1 !== e.rl || last1 !== e.last)
                $display("FAIL single_index: got row=%0d col=%0d rl=%0b last=%0b, want 0 0 1 1",
                         row1, col1, row_last1, last1);
            else n_pass++;
        end
        @(negedge clk);
        idx_ready1 = 1'b0;
        n_total++;
        if ({done1, idx_valid1, busy1} !== 3'b101)
            $display("FAIL single_done: got done/valid/busy=%b, want 101", {done1, idx_valid1, busy1});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done1, idx_valid1, busy1} !== 3'b000)
            $display("FAIL single_idle: got done/valid/busy=%b, want 000", {done1, idx_valid1, busy1});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_abort();
        test_restart_after_abort();
        test_start_mid_run();
        test_reset_mid_run();
        test_single_tile();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
